// File: rtl/bc_digit_entry.sv
// Keyed-digit entry: assembles hex/octal keystrokes plus an optional sign into
// an N-bit word (unsigned or two's complement), committing it on enter.
module bc_digit_entry #(
   parameter int N = 10
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [1:0]   i_op,
   input  logic [3:0]   i_digit_in,
   input  logic         i_digit_valid,
   input  logic         i_neg_toggle,
   input  logic         i_enter,
   input  logic         i_clear,
   output logic [N-1:0] o_B_out,
   output logic         o_B_valid,
   output logic [N-1:0] o_mag_live,
   output logic         o_neg_live,
   output logic         o_entry_active,
   output logic         o_digit_reject,
   output logic         o_err
);

   typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_ERROR} state_t;

   localparam logic [N-1:0] L_POS_MAX = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] L_NEG_MAX = {1'b1, {(N-1){1'b0}}};
   localparam logic [N-1:0] L_ONE     = {{(N-1){1'b0}}, 1'b1};

   state_t       r_state, w_state_nxt;
   logic [1:0]   r_op, w_op_nxt;
   logic [N-1:0] r_acc, w_acc_nxt;
   logic         r_neg, w_neg_nxt;
   logic [N-1:0] r_bout, w_bout_nxt;
   logic         r_bvalid, w_bvalid_nxt;
   logic         r_reject, w_reject_nxt;

   logic         w_base16;
   logic         w_legal;
   logic [N+3:0] w_prod;
   logic [N+3:0] w_sum;
   logic         w_ovf;
   logic         w_in_range;
   logic [N-1:0] w_commit;

   // In IDLE the op on the port decides the base, since it is latched this cycle.
   assign w_base16   = (r_state == S_IDLE) ? ~i_op[0] : ~r_op[0];
   assign w_legal    = w_base16 | ~i_digit_in[3];
   assign w_prod     = w_base16 ? {r_acc, 4'b0000} : {1'b0, r_acc, 3'b000};
   assign w_sum      = w_prod + {{N{1'b0}}, i_digit_in};
   assign w_ovf      = |w_sum[N+3:N];
   assign w_in_range = ~r_op[1] | (r_neg ? (r_acc <= L_NEG_MAX) : (r_acc <= L_POS_MAX));
   assign w_commit   = r_neg ? (~r_acc + L_ONE) : r_acc;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_op     <= 2'b00;
         r_acc    <= '0;
         r_neg    <= 1'b0;
         r_bout   <= '0;
         r_bvalid <= 1'b0;
         r_reject <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_op     <= w_op_nxt;
         r_acc    <= w_acc_nxt;
         r_neg    <= w_neg_nxt;
         r_bout   <= w_bout_nxt;
         r_bvalid <= w_bvalid_nxt;
         r_reject <= w_reject_nxt;
      end
   end

   // Only the highest-priority pulse is acted on: clear > enter > digit > neg.
   always_comb begin
      w_state_nxt  = r_state;
      w_op_nxt     = r_op;
      w_acc_nxt    = r_acc;
      w_neg_nxt    = r_neg;
      w_bout_nxt   = r_bout;
      w_bvalid_nxt = 1'b0;
      w_reject_nxt = 1'b0;
      if (i_clear) begin
         w_state_nxt = S_IDLE;
         w_acc_nxt   = '0;
         w_neg_nxt   = 1'b0;
      end else if (i_enter) begin
         if (r_state == S_ENTRY) begin
            if (w_in_range) begin
               w_bout_nxt   = w_commit;
               w_bvalid_nxt = 1'b1;
               w_acc_nxt    = '0;
               w_neg_nxt    = 1'b0;
               w_state_nxt  = S_IDLE;
            end else begin
               w_state_nxt = S_ERROR;
            end
         end
      end else if (i_digit_valid) begin
         case (r_state)
            S_IDLE: begin
               if (w_legal) begin
                  w_acc_nxt   = {{(N-4){1'b0}}, i_digit_in};
                  w_op_nxt    = i_op;
                  w_state_nxt = S_ENTRY;
               end else begin
                  w_reject_nxt = 1'b1;
               end
            end
            S_ENTRY: begin
               if (!w_legal)    w_reject_nxt = 1'b1;
               else if (w_ovf)  w_state_nxt  = S_ERROR;
               else             w_acc_nxt    = w_sum[N-1:0];
            end
            default: ;
         endcase
      end else if (i_neg_toggle) begin
         if (r_state == S_IDLE && i_op[1]) begin
            w_neg_nxt   = ~r_neg;
            w_op_nxt    = i_op;
            w_state_nxt = S_ENTRY;
         end else if (r_state == S_ENTRY && r_op[1]) begin
            w_neg_nxt = ~r_neg;
         end
      end
   end

   assign o_B_out        = r_bout;
   assign o_B_valid      = r_bvalid;
   assign o_mag_live     = r_acc;
   assign o_neg_live     = r_neg;
   assign o_entry_active = (r_state == S_ENTRY);
   assign o_digit_reject = r_reject;
   assign o_err          = (r_state == S_ERROR);

endmodule

// File: tb/tb_bc_digit_entry.sv
// Directed bench for bc_digit_entry; committed words are checked against a
// queue of expected values filled as each commit is keyed in.
module tb_bc_digit_entry;
   localparam int N = 10;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   op;
   logic [3:0]   digit;
   logic         dv, nt, en, cl;
   logic [N-1:0] B_out, mag;
   logic         B_valid, neg_live, active, reject, err;

   int n_checks = 0;
   int n_fail   = 0;
   logic [N-1:0] sb_q[$];

   bc_digit_entry #(.N(N)) dut (
      .i_clk(clk), .i_rst(rst), .i_op(op), .i_digit_in(digit),
      .i_digit_valid(dv), .i_neg_toggle(nt), .i_enter(en), .i_clear(cl),
      .o_B_out(B_out), .o_B_valid(B_valid), .o_mag_live(mag),
      .o_neg_live(neg_live), .o_entry_active(active),
      .o_digit_reject(reject), .o_err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock with the given pulses, returning at the next falling edge.
   task automatic drive(input logic d_v, input logic [3:0] d, input logic d_nt,
                        input logic d_en, input logic d_cl);
      dv = d_v; digit = d; nt = d_nt; en = d_en; cl = d_cl;
      @(negedge clk);
      dv = 1'b0; nt = 1'b0; en = 1'b0; cl = 1'b0; digit = 4'h0;
   endtask

   task automatic dig(input logic [3:0] d); drive(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
   task automatic ngt();  drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0); endtask
   task automatic ent();  drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0); endtask
   task automatic clr();  drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1); endtask
   task automatic idle(); drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0); endtask

   // Scoreboard: every B_valid pulse must match the oldest expected commit.
   always @(negedge clk) begin
      if (!rst && B_valid) begin
         n_checks++;
         assert (sb_q.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_extra observed=%0h expected=none", B_out);
         end
         if (sb_q.size() != 0) chk("sb_bout", B_out, sb_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; op = 2'b00; digit = 4'h0; dv = 0; nt = 0; en = 0; cl = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_bout", B_out, 0);
      chk("rst_flags", {B_valid, neg_live, active, reject, err}, 5'b0);
      chk("rst_mag", mag, 0);

      // unsigned hex 3FF
      op = 2'b00;
      dig(4'h3);
      chk("t1_mag3", mag, 10'h003);
      chk("t1_active", active, 1);
      dig(4'hF); dig(4'hF);
      chk("t1_mag", mag, 10'h3FF);
      sb_q.push_back(10'h3FF);
      ent();
      chk("t1_bvalid", B_valid, 1);
      chk("t1_inactive", active, 0);
      chk("t1_mag0", mag, 0);
      idle();
      chk("t1_pulse1", B_valid, 0);
      chk("t1_hold", B_out, 10'h3FF);

      // unsigned hex overflow
      dig(4'h4); dig(4'h0);
      chk("t2_mag", mag, 10'h040);
      dig(4'h0);
      chk("t2_err", err, 1);
      chk("t2_acc_kept", mag, 10'h040);
      ent();
      chk("t2_no_commit", B_valid, 0);
      dig(4'hF);
      chk("t2_no_reject", reject, 0);
      chk("t2_still_err", err, 1);
      clr();
      chk("t2_clr", {err, active, neg_live}, 3'b0);
      chk("t2_clr_mag", mag, 0);
      chk("t2_bout_kept", B_out, 10'h3FF);

      // signed octal -512 and +512 out of range
      op = 2'b11;
      ngt();
      chk("t3_neg", neg_live, 1);
      chk("t3_active", active, 1);
      dig(4'h1); dig(4'h0); dig(4'h0); dig(4'h0);
      chk("t3_mag", mag, 10'h200);
      sb_q.push_back(10'h200);
      ent();
      chk("t3_bvalid", B_valid, 1);
      chk("t3_neg_cleared", neg_live, 0);
      dig(4'h1); dig(4'h0); dig(4'h0); dig(4'h0);
      ent();
      chk("t3_range_err", err, 1);
      chk("t3_no_commit", B_valid, 0);
      chk("t3_bout_kept", B_out, 10'h200);
      clr();

      // octal reject, op latched mid-entry
      op = 2'b01;
      dig(4'h9);
      chk("t4_reject", reject, 1);
      chk("t4_idle", active, 0);
      chk("t4_mag", mag, 0);
      idle();
      chk("t4_reject_1cyc", reject, 0);
      dig(4'h7);
      op = 2'b00;
      dig(4'h8);
      chk("t4_latched_reject", reject, 1);
      chk("t4_mag_kept", mag, 10'd7);
      dig(4'h7);
      chk("t4_mag77", mag, 10'd63);
      sb_q.push_back(10'd63);
      ent();
      chk("t4_bout", B_out, 10'd63);

      // same-cycle priority
      dig(4'h5);
      drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
      chk("t5_clr_beats_ent", B_valid, 0);
      chk("t5_idle", active, 0);
      chk("t5_mag0", mag, 0);
      dig(4'h2);
      sb_q.push_back(10'h002);
      drive(1'b1, 4'h3, 1'b0, 1'b1, 1'b0);
      chk("t5_ent_beats_dig", B_out, 10'h002);
      chk("t5_mag_after", mag, 0);

      // reset mid-entry
      dig(4'h1); dig(4'h2);
      chk("t6_mag", mag, 10'h012);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_rst_bout", B_out, 0);
      chk("t6_rst_all", {mag, B_valid, neg_live, active, reject, err}, 15'b0);
      dig(4'h5);
      sb_q.push_back(10'h005);
      ent();
      chk("t6_bout", B_out, 10'h005);

      // signed hex boundaries, leading zeros, unsigned sign ignored
      op = 2'b10;
      dig(4'h1); dig(4'hF); dig(4'hF);
      sb_q.push_back(10'h1FF);
      ent();
      chk("b_posmax", B_out, 10'h1FF);
      ngt(); dig(4'h5);
      sb_q.push_back(10'h3FB);
      ent();
      chk("b_neg5", B_out, 10'h3FB);
      ngt(); ngt();
      chk("b_neg_twice", neg_live, 0);
      dig(4'h2); dig(4'h0); dig(4'h1);
      ngt();
      ent();
      chk("b_negmax_plus1_err", err, 1);
      clr();
      op = 2'b00;
      ngt();
      chk("b_uns_neg_ignored", {neg_live, active}, 2'b00);
      dig(4'h0); dig(4'h0); dig(4'h3); dig(4'hF); dig(4'hF);
      chk("b_lead_zeros", {err, mag}, {1'b0, 10'h3FF});
      ngt();
      chk("b_uns_neg_entry", neg_live, 0);
      sb_q.push_back(10'h3FF);
      ent();
      idle();

      chk("sb_drain", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
